// File: rtl/vx_exec_dispatch_arb_if.sv
// Dispatch-lane request bundle and functional-unit output handshake for vx_exec_dispatch_arb.
// slave modport faces the arbiter; master modport faces the lanes and the downstream unit.
interface vx_exec_dispatch_arb_if #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int SEL_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQS-1:0]            req_ready;
  logic                           out_valid;
  logic [DATA_WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]               out_sel;
  logic                           out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/vx_exec_dispatch_arb.sv
// Round-robin arbiter sharing one execute unit among NUM_REQS dispatch lanes, with a registered output stage.
// Optional saturating stall/conflict counters are enabled by defining VX_ARB_PERF_EN.
module vx_exec_dispatch_arb #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  vx_exec_dispatch_arb_if.slave    bus
`ifdef VX_ARB_PERF_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_conflict_cycles
`endif
);
  localparam int SEL_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [SEL_W-1:0]      last_grant_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0]      out_sel_r;

  logic                  pipe_ready_s;
  logic                  grant_found_s;
  logic [SEL_W-1:0]      grant_idx_s;
  logic [DATA_WIDTH-1:0] win_data_s;
  logic                  xfer_s;
  logic [NUM_REQS-1:0]   req_ready_s;

  assign pipe_ready_s = !out_valid_r || bus.out_ready;
  // No handshake is offered while reset is held, so lanes never see a phantom accept.
  assign xfer_s       = grant_found_s && pipe_ready_s && !flush && reset_n;

  // Round-robin search starting one past the last lane that actually transferred.
  always_comb begin
    int idx;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 1; k <= NUM_REQS; k++) begin
      idx = (int'(last_grant_r) + k) % NUM_REQS;
      if (!grant_found_s && bus.req_valid[idx]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = SEL_W'(idx);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Per-lane accept and payload mux for the granted lane.
  always_comb begin
    req_ready_s = '0;
    win_data_s  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx_s == SEL_W'(i)) begin
        req_ready_s[i] = xfer_s;
        win_data_s     = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  // Output pipeline stage and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_sel_r    <= '0;
      last_grant_r <= SEL_W'(NUM_REQS - 1);
    end else if (flush) begin
      out_valid_r  <= 1'b0;
    end else if (xfer_s) begin
      out_valid_r  <= 1'b1;
      out_data_r   <= win_data_s;
      out_sel_r    <= grant_idx_s;
      last_grant_r <= grant_idx_s;
    end else if (bus.out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;

`ifdef VX_ARB_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_conflict_r;
  logic        stall_s;
  logic        conflict_s;

  assign stall_s    = out_valid_r && !bus.out_ready;
  assign conflict_s = ($countones(bus.req_valid) >= 2) && pipe_ready_s && !flush;

  // Saturating counters; flush intentionally leaves them untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_r    <= 32'd0;
      perf_conflict_r <= 32'd0;
    end else begin
      if (stall_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
      if (conflict_s && (perf_conflict_r != 32'hFFFF_FFFF)) begin
        perf_conflict_r <= perf_conflict_r + 32'd1;
      end else begin
        perf_conflict_r <= perf_conflict_r;
      end
    end
  end

  assign perf_stall_cycles    = perf_stall_r;
  assign perf_conflict_cycles = perf_conflict_r;
`endif
endmodule

// File: tb/tb_vx_exec_dispatch_arb.sv
// Self-checking bench for vx_exec_dispatch_arb: directed scenarios plus a randomized run against a
// transaction-level model. Perf counter checks are included when VX_ARB_PERF_EN is defined.
module tb_vx_exec_dispatch_arb;
  localparam int N  = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  always #5 clk = ~clk;

  vx_exec_dispatch_arb_if #(.NUM_REQS(N), .DATA_WIDTH(DW)) bus ();

`ifdef VX_ARB_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_conflict_cycles;
`endif

  vx_exec_dispatch_arb #(.NUM_REQS(N), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus.slave)
`ifdef VX_ARB_PERF_EN
    ,
    .perf_stall_cycles    (perf_stall_cycles),
    .perf_conflict_cycles (perf_conflict_cycles)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int            m_last;
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_sel;
  longint        m_stall, m_conf;
  // Next-state computed for the current inputs
  logic [N-1:0]  exp_ready;
  int            n_last, n_sel;
  logic          n_valid;
  logic [DW-1:0] n_data;
  longint        n_stall, n_conf;

  function automatic int pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = {$urandom(), $urandom()};
    return d;
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_valid = 1'b0; m_data = '0; m_sel = 0; m_stall = 0; m_conf = 0;
  endtask

  // Apply inputs and work out what the spec says happens at the next edge.
  task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic fl, input logic ordy);
    int  g;
    bit  pr;
    bus.req_valid = v; bus.req_data = d; flush = fl; bus.out_ready = ordy;
    #1;
    pr = !m_valid || ordy;
    g  = pick(v, m_last);
    exp_ready = '0;
    n_valid = m_valid; n_data = m_data; n_sel = m_sel; n_last = m_last;
    n_stall = m_stall; n_conf = m_conf;
    if (m_valid && !ordy && n_stall < 64'hFFFF_FFFF) n_stall++;
    if ($countones(v) >= 2 && pr && !fl && n_conf < 64'hFFFF_FFFF) n_conf++;
    if (fl) begin
      n_valid = 1'b0;
    end else if (g >= 0 && pr && reset_n) begin
      exp_ready[g] = 1'b1;
      n_valid = 1'b1; n_data = d[g*DW +: DW]; n_sel = g; n_last = g;
    end else if (ordy) begin
      n_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    m_valid = n_valid; m_data = n_data; m_sel = n_sel; m_last = n_last;
    m_stall = n_stall; m_conf = n_conf;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; flush = 1'b0; bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    drive(4'b1111, rand_data(), 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000 || bus.out_sel !== 2'd0 || bus.out_data !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_state: valid=%b ready=%b sel=%0d data=%h required 0/0000/0/0",
               bus.out_valid, bus.req_ready, bus.out_sel, bus.out_data);
    end
    reset_n = 1'b1;
    drive(4'b1111, rand_data(), 1'b0, 1'b1);
    compared++;
    if (bus.req_ready !== 4'b0001) begin
      mismatched++; $display("FAIL reset_first_grant: ready=%b required 0001", bus.req_ready);
    end
    tick();
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== m_data) begin
      mismatched++;
      $display("FAIL reset_first_out: valid=%b sel=%0d data=%h required 1/0/%h", bus.out_valid, bus.out_sel, bus.out_data, m_data);
    end
    // Reset asserted while a result is held: output must drop without waiting for a clock.
    drive(4'b0010, rand_data(), 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      mismatched++; $display("FAIL reset_async: valid=%b ready=%b required 0/0000", bus.out_valid, bus.req_ready);
    end
    model_reset();
    do_reset();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, rand_data(), 1'b0, 1'b1);
      compared++;
      if (bus.req_ready !== exp_ready) begin
        mismatched++; $display("FAIL rr_ready[%0d]: ready=%b required %b", i, bus.req_ready, exp_ready);
      end
      tick();
      compared++;
      if (bus.out_valid !== 1'b1 || int'(bus.out_sel) != (i % N) || bus.out_data !== m_data) begin
        mismatched++;
        $display("FAIL rr_out[%0d]: valid=%b sel=%0d data=%h required 1/%0d/%h", i, bus.out_valid, bus.out_sel, bus.out_data, i % N, m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N*DW-1:0] d;
    do_reset();
    d = rand_data();
    d[2*DW +: DW] = 64'h0000_0000_0000_00A5;
    drive(4'b0100, d, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, rand_data(), 1'b0, 1'b0);
      compared++;
      if (bus.req_ready !== 4'b0000) begin
        mismatched++; $display("FAIL bp_ready[%0d]: ready=%b required 0000", i, bus.req_ready);
      end
      tick();
      compared++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== 64'h0000_0000_0000_00A5) begin
        mismatched++;
        $display("FAIL bp_hold[%0d]: valid=%b sel=%0d data=%h required 1/2/a5", i, bus.out_valid, bus.out_sel, bus.out_data);
      end
    end
    drive(4'b1111, rand_data(), 1'b0, 1'b1);
    compared++;
    if (bus.req_ready !== 4'b1000) begin
      mismatched++; $display("FAIL bp_resume_ready: ready=%b required 1000", bus.req_ready);
    end
    tick();
    compared++;
    if (bus.out_sel !== 2'd3 || bus.out_data !== m_data) begin
      mismatched++; $display("FAIL bp_resume_out: sel=%0d data=%h required 3/%h", bus.out_sel, bus.out_data, m_data);
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    drive(4'b1000, rand_data(), 1'b0, 1'b1);
    tick();
    drive(4'b0100, rand_data(), 1'b0, 1'b1);
    compared++;
    if (bus.req_ready !== 4'b0100) begin
      mismatched++; $display("FAIL sparse_ready: ready=%b required 0100", bus.req_ready);
    end
    tick();
    compared++;
    if (bus.out_sel !== 2'd2) begin
      mismatched++; $display("FAIL sparse_sel: sel=%0d required 2", bus.out_sel);
    end
    drive(4'b0011, rand_data(), 1'b0, 1'b1);
    compared++;
    if (bus.req_ready !== 4'b0001) begin
      mismatched++; $display("FAIL wrap_ready: ready=%b required 0001", bus.req_ready);
    end
    tick();
    compared++;
    if (bus.out_sel !== 2'd0 || bus.out_data !== m_data) begin
      mismatched++; $display("FAIL wrap_out: sel=%0d data=%h required 0/%h", bus.out_sel, bus.out_data, m_data);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(4'b0001, rand_data(), 1'b0, 1'b1);
    tick();
    drive(4'b0011, rand_data(), 1'b1, 1'b1);
    compared++;
    if (bus.req_ready !== 4'b0000) begin
      mismatched++; $display("FAIL flush_ready: ready=%b required 0000", bus.req_ready);
    end
    tick();
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++; $display("FAIL flush_valid: valid=%b required 0", bus.out_valid);
    end
    // Pointer must still sit at lane 0, so lane 1 wins over lane 0.
    drive(4'b0011, rand_data(), 1'b0, 1'b1);
    compared++;
    if (bus.req_ready !== 4'b0010) begin
      mismatched++; $display("FAIL flush_resume_ready: ready=%b required 0010", bus.req_ready);
    end
    tick();
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1) begin
      mismatched++; $display("FAIL flush_resume_out: valid=%b sel=%0d required 1/1", bus.out_valid, bus.out_sel);
    end
    drive(4'b0000, rand_data(), 1'b1, 1'b0);
    tick();
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++; $display("FAIL flush_over_stall: valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), rand_data(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
      compared++;
      if (bus.req_ready !== exp_ready) begin
        mismatched++; $display("FAIL rand_ready[%0d]: ready=%b required %b", i, bus.req_ready, exp_ready);
      end
      tick();
      compared++;
      if (bus.out_valid !== m_valid || int'(bus.out_sel) != m_sel || bus.out_data !== m_data) begin
        mismatched++;
        $display("FAIL rand_out[%0d]: valid=%b sel=%0d data=%h required %b/%0d/%h",
                 i, bus.out_valid, bus.out_sel, bus.out_data, m_valid, m_sel, m_data);
      end
`ifdef VX_ARB_PERF_EN
      compared++;
      if (perf_stall_cycles != 32'(m_stall) || perf_conflict_cycles != 32'(m_conf)) begin
        mismatched++;
        $display("FAIL rand_perf[%0d]: stall=%0d conflict=%0d required %0d/%0d", i, perf_stall_cycles, perf_conflict_cycles, m_stall, m_conf);
      end
`endif
    end
  endtask

`ifdef VX_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    drive(4'b0001, rand_data(), 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0000, rand_data(), 1'b0, 1'b0);
      tick();
    end
    compared++;
    if (perf_stall_cycles !== 32'd5) begin
      mismatched++; $display("FAIL perf_stall: count=%0d required 5", perf_stall_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, rand_data(), 1'b0, 1'b1);
      tick();
    end
    compared++;
    if (perf_conflict_cycles !== 32'd3) begin
      mismatched++; $display("FAIL perf_conflict: count=%0d required 3", perf_conflict_cycles);
    end
    force dut.perf_stall_r = 32'hFFFF_FFFF;
    #1;
    release dut.perf_stall_r;
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, rand_data(), 1'b0, 1'b0);
      tick();
    end
    compared++;
    if (perf_stall_cycles !== 32'hFFFF_FFFF) begin
      mismatched++; $display("FAIL perf_saturate: count=%h required ffffffff", perf_stall_cycles);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_flush();
`ifdef VX_ARB_PERF_EN
    test_perf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
